gemm_tile_scheduler: RTL and testbench
======================================

GEMM_TILE_SCHEDULER -- requirements
Module: gemm_tile_scheduler

Interface
REQ-001 Parameters, one per line: NUM_ROW, default 8, array rows; NUM_COL, default 8, array columns; LOG2_SRAM_BANK_DEPTH, default 10, SRAM address width; TILE_CNT_WIDTH, default 8, tile counter width; CTRL_WIDTH, default 4, controller state width.
REQ-002 clk  input  1  single clock, rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 i_start  input  1  one-cycle job launch; sampled only in S_IDLE.
REQ-005 i_abort  input  1  terminates the job; forces S_IDLE on the next edge.
REQ-006 i_num_m_tiles, i_num_n_tiles  input  TILE_CNT_WIDTH each  left (M) and top (N) tile counts.
REQ-007 i_k_len  input  LOG2_SRAM_BANK_DEPTH  operand rows per tile.
REQ-008 i_top_base, i_left_base, i_out_base  input  LOG2_SRAM_BANK_DEPTH each  SRAM base addresses.
REQ-009 i_sa_valid_down  input  NUM_COL  array output valids.
REQ-010 o_ctrl_state  output  CTRL_WIDTH  state to the array controller: IDLE=0, STEADY=1, DRAIN=3.
REQ-011 o_top_rd_start_addr, o_top_rd_end_addr, o_left_rd_start_addr, o_left_rd_end_addr  output  LOG2_SRAM_BANK_DEPTH each  current tile operand window.
REQ-012 o_out_base_addr  output  LOG2_SRAM_BANK_DEPTH  result base for the current tile.
REQ-013 o_busy  output  1  high from S_LOAD through S_NEXT.
REQ-014 o_done  output  1  one-cycle pulse at job completion.
REQ-015 o_tile_m, o_tile_n  output  TILE_CNT_WIDTH each  current tile indices.

Function
REQ-016 FSM states: S_IDLE, S_LOAD, S_STEADY, S_DRAIN, S_NEXT.
REQ-017 S_IDLE with i_start=1 and nonzero operands latches all job inputs, clears the tile indices and goes to S_LOAD.
REQ-018 If any of i_num_m_tiles, i_num_n_tiles or i_k_len is 0 at start, the block pulses o_done on the next cycle and stays in S_IDLE.
REQ-019 S_LOAD lasts exactly 1 cycle with o_ctrl_state=IDLE and the tile addresses stable, so the controller preloads its read pointers.
REQ-020 S_STEADY drives o_ctrl_state=STEADY for exactly k + NUM_ROW + NUM_COL - 1 cycles, where k is the latched i_k_len.
REQ-021 S_DRAIN drives o_ctrl_state=DRAIN and counts cycles with i_sa_valid_down[NUM_COL-1]=1.
REQ-022 S_DRAIN exits to S_NEXT one cycle after the NUM_ROW-th counted beat.
REQ-023 In S_NEXT (1 cycle, o_ctrl_state=IDLE), n increments; if n was the last N tile, n wraps to 0 and m increments.
REQ-024 S_NEXT goes to S_LOAD if tiles remain; otherwise it pulses o_done and goes to S_IDLE.
REQ-025 Address computation:
  - top start = top_base + n*k
  - left start = left_base + m*k
  - end = start + k
  - out base = out_base + (m*num_n + n)*NUM_ROW
  - all arithmetic is modulo 2^LOG2_SRAM_BANK_DEPTH
  - addresses are registered and updated in S_NEXT and on start.
REQ-026 i_abort has priority over every other event, including a simultaneous i_start or a drain exit: the next state is S_IDLE, o_ctrl_state=IDLE, and o_done is not pulsed.
REQ-027 i_start outside S_IDLE is ignored, and latched job inputs do not change mid-job.
REQ-028 i_sa_valid_down is ignored outside S_DRAIN.

Reset
REQ-029 On rst_n low, all outputs clear asynchronously:
  - state S_IDLE, o_ctrl_state 0
  - all addresses 0
  - o_busy 0, o_done 0
  - tile indices 0
  - all counters 0.
REQ-030 Reset mid-job abandons the job with no o_done pulse; the first start after reset behaves as a fresh launch.

Structure
REQ-031 The shared package holds the CTRL_WIDTH constant, the IDLE/STEADY/DRAIN encodings and the FSM state encoding.
REQ-032 One sub-module, gemm_tile_addr_gen, holds the index and address registers and the mod-2^N arithmetic, with an advance strobe and a clear strobe; the FSM and cycle counters stay in the top module.

Verification
REQ-033 Start with m=1, n=1, k=4, bases 0 and NUM_ROW=NUM_COL=8, then NUM_ROW drain valids -> addresses top 0..4 and left 0..4; LOAD 1 cycle; STEADY 19 cycles; DRAIN; o_done pulses once.
REQ-034 Start with m=2, n=2, k=3, top_base=10, left_base=20, out_base=100 -> tile order (0,0),(0,1),(1,0),(1,1); top starts 10,13,10,13; left starts 20,20,23,23; out bases 100,108,116,124.
REQ-035 Start with k=0 -> o_done one cycle later; o_busy stays 0; o_ctrl_state stays IDLE.
REQ-036 Raise i_abort during the second tile's STEADY -> next cycle S_IDLE with o_ctrl_state 0 and no o_done; a new start then runs correctly.
REQ-037 Set top_base=1020 with k=8 and LOG2_SRAM_BANK_DEPTH=10 -> end address wraps to 4; i_start pulsed mid-job is ignored.
REQ-038 Assert rst_n low during DRAIN -> all outputs 0 immediately; a new start after reset completes normally.

Source files
------------

// File: rtl/gemm_tile_scheduler_pkg.sv
// Shared encodings for the GEMM tile scheduler: controller state codes and FSM states.
package gemm_tile_scheduler_pkg;

    localparam int CTRL_W = 4;

    localparam logic [CTRL_W-1:0] CTRL_IDLE   = 4'd0;
    localparam logic [CTRL_W-1:0] CTRL_STEADY = 4'd1;
    localparam logic [CTRL_W-1:0] CTRL_DRAIN  = 4'd3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_STEADY = 3'd2,
        S_DRAIN  = 3'd3,
        S_NEXT   = 3'd4
    } sched_state_e;

    function automatic logic [CTRL_W-1:0] ctrl_code(input sched_state_e s);
        case (s)
            S_STEADY: return CTRL_STEADY;
            S_DRAIN:  return CTRL_DRAIN;
            default:  return CTRL_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/gemm_tile_addr_gen.sv
// Tile index and SRAM window registers; addresses advance incrementally so every
// sum wraps naturally at the address width.
module gemm_tile_addr_gen
    import gemm_tile_scheduler_pkg::*;
#(
    parameter int NUM_ROW = 8,
    parameter int ADDR_W  = 10,
    parameter int TILE_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              advance,
    input  logic [TILE_W-1:0] num_m_tiles,
    input  logic [TILE_W-1:0] num_n_tiles,
    input  logic [ADDR_W-1:0] k_len,
    input  logic [ADDR_W-1:0] top_base,
    input  logic [ADDR_W-1:0] left_base,
    input  logic [ADDR_W-1:0] out_base,
    output logic [ADDR_W-1:0] k_lat,
    output logic [ADDR_W-1:0] top_start,
    output logic [ADDR_W-1:0] top_end,
    output logic [ADDR_W-1:0] left_start,
    output logic [ADDR_W-1:0] left_end,
    output logic [ADDR_W-1:0] out_addr,
    output logic [TILE_W-1:0] tile_m,
    output logic [TILE_W-1:0] tile_n,
    output logic              last_tile
);

    logic [TILE_W-1:0] num_m_q;
    logic [TILE_W-1:0] num_n_q;
    logic [ADDR_W-1:0] top_base_q;
    logic              n_last;

    assign n_last    = (tile_n == num_n_q - TILE_W'(1));
    assign last_tile = n_last && (tile_m == num_m_q - TILE_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_m_q    <= '0;
            num_n_q    <= '0;
            k_lat      <= '0;
            top_base_q <= '0;
            tile_m     <= '0;
            tile_n     <= '0;
            top_start  <= '0;
            top_end    <= '0;
            left_start <= '0;
            left_end   <= '0;
            out_addr   <= '0;
        end else if (clear) begin
            num_m_q    <= num_m_tiles;
            num_n_q    <= num_n_tiles;
            k_lat      <= k_len;
            top_base_q <= top_base;
            tile_m     <= '0;
            tile_n     <= '0;
            top_start  <= top_base;
            top_end    <= top_base + k_len;
            left_start <= left_base;
            left_end   <= left_base + k_len;
            out_addr   <= out_base;
        end else if (advance) begin
            // tiles are laid out row-major in the output bank, so each step is one tile
            out_addr <= out_addr + ADDR_W'(NUM_ROW);
            if (n_last) begin
                tile_n     <= '0;
                tile_m     <= tile_m + TILE_W'(1);
                top_start  <= top_base_q;
                top_end    <= top_base_q + k_lat;
                left_start <= left_start + k_lat;
                left_end   <= left_end + k_lat;
            end else begin
                tile_n    <= tile_n + TILE_W'(1);
                top_start <= top_start + k_lat;
                top_end   <= top_end + k_lat;
            end
        end
    end

endmodule

// File: rtl/gemm_tile_scheduler.sv
// Walks a GEMM job tile by tile, sequencing the systolic array controller
// through load, steady-state streaming and drain for each tile.
//
// state    | meaning
// S_IDLE   | waiting for i_start; zero-sized jobs complete here
// S_LOAD   | one cycle, tile window stable for pointer preload
// S_STEADY | operands streaming for k + NUM_ROW + NUM_COL - 1 cycles
// S_DRAIN  | counting NUM_ROW last-column output beats
// S_NEXT   | advance tile indices, finish or load next tile
module gemm_tile_scheduler
    import gemm_tile_scheduler_pkg::*;
#(
    parameter int NUM_ROW              = 8,
    parameter int NUM_COL              = 8,
    parameter int LOG2_SRAM_BANK_DEPTH = 10,
    parameter int TILE_CNT_WIDTH       = 8,
    parameter int CTRL_WIDTH           = CTRL_W
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_start,
    input  logic                            i_abort,
    input  logic [TILE_CNT_WIDTH-1:0]       i_num_m_tiles,
    input  logic [TILE_CNT_WIDTH-1:0]       i_num_n_tiles,
    input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_k_len,
    input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_top_base,
    input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_left_base,
    input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_out_base,
    input  logic [NUM_COL-1:0]              i_sa_valid_down,
    output logic [CTRL_WIDTH-1:0]           o_ctrl_state,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_top_rd_start_addr,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_top_rd_end_addr,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_left_rd_start_addr,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_left_rd_end_addr,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_out_base_addr,
    output logic                            o_busy,
    output logic                            o_done,
    output logic [TILE_CNT_WIDTH-1:0]       o_tile_m,
    output logic [TILE_CNT_WIDTH-1:0]       o_tile_n
);

    localparam int CNT_W = LOG2_SRAM_BANK_DEPTH + $clog2(NUM_ROW + NUM_COL) + 1;

    sched_state_e                    state_q, state_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic                            done_q, done_d;
    logic                            addr_clear;
    logic                            addr_advance;
    logic                            last_tile;
    logic                            zero_job;
    logic                            sa_last_valid;
    logic                            unused_valid_bits;
    logic [LOG2_SRAM_BANK_DEPTH-1:0] k_lat;

    assign zero_job          = (i_num_m_tiles == '0) || (i_num_n_tiles == '0) || (i_k_len == '0);
    assign sa_last_valid     = i_sa_valid_down[NUM_COL-1];
    assign unused_valid_bits = ^i_sa_valid_down;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        done_d       = 1'b0;
        addr_clear   = 1'b0;
        addr_advance = 1'b0;
        if (i_abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        if (zero_job) begin
                            done_d = 1'b1;
                        end else begin
                            addr_clear = 1'b1;
                            state_d    = S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    // terminal count at 0 gives k + NUM_ROW + NUM_COL - 1 steady cycles
                    cnt_d   = CNT_W'(k_lat) + CNT_W'(NUM_ROW + NUM_COL - 2);
                    state_d = S_STEADY;
                end
                S_STEADY: begin
                    if (cnt_q == '0) begin
                        cnt_d   = CNT_W'(NUM_ROW - 1);
                        state_d = S_DRAIN;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (sa_last_valid) begin
                        if (cnt_q == '0) begin
                            state_d = S_NEXT;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end
                S_NEXT: begin
                    addr_advance = 1'b1;
                    if (last_tile) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign o_ctrl_state = CTRL_WIDTH'(ctrl_code(state_q));
    assign o_busy       = (state_q != S_IDLE);
    assign o_done       = done_q;

    gemm_tile_addr_gen #(
        .NUM_ROW (NUM_ROW),
        .ADDR_W  (LOG2_SRAM_BANK_DEPTH),
        .TILE_W  (TILE_CNT_WIDTH)
    ) u_addr_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (addr_clear),
        .advance     (addr_advance),
        .num_m_tiles (i_num_m_tiles),
        .num_n_tiles (i_num_n_tiles),
        .k_len       (i_k_len),
        .top_base    (i_top_base),
        .left_base   (i_left_base),
        .out_base    (i_out_base),
        .k_lat       (k_lat),
        .top_start   (o_top_rd_start_addr),
        .top_end     (o_top_rd_end_addr),
        .left_start  (o_left_rd_start_addr),
        .left_end    (o_left_rd_end_addr),
        .out_addr    (o_out_base_addr),
        .tile_m      (o_tile_m),
        .tile_n      (o_tile_n),
        .last_tile   (last_tile)
    );

endmodule

// File: tb/tb_gemm_tile_scheduler.sv
// Directed bench for gemm_tile_scheduler with hand-computed tile windows and cycle counts.
module tb_gemm_tile_scheduler;

    localparam int NUM_ROW = 8;
    localparam int NUM_COL = 8;
    localparam int AW      = 10;
    localparam int TW      = 8;
    localparam int CW      = 4;

    typedef logic [2*TW+5*AW-1:0] tile_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          i_start = 1'b0;
    logic          i_abort = 1'b0;
    logic [TW-1:0] i_num_m_tiles = '0;
    logic [TW-1:0] i_num_n_tiles = '0;
    logic [AW-1:0] i_k_len = '0;
    logic [AW-1:0] i_top_base = '0;
    logic [AW-1:0] i_left_base = '0;
    logic [AW-1:0] i_out_base = '0;
    logic [NUM_COL-1:0] i_sa_valid_down = '0;
    logic [CW-1:0] o_ctrl_state;
    logic [AW-1:0] o_top_rd_start_addr, o_top_rd_end_addr;
    logic [AW-1:0] o_left_rd_start_addr, o_left_rd_end_addr;
    logic [AW-1:0] o_out_base_addr;
    logic          o_busy, o_done;
    logic [TW-1:0] o_tile_m, o_tile_n;

    int vectors = 0;
    int miscompares = 0;
    int done_seen = 0;

    gemm_tile_scheduler #(
        .NUM_ROW              (NUM_ROW),
        .NUM_COL              (NUM_COL),
        .LOG2_SRAM_BANK_DEPTH (AW),
        .TILE_CNT_WIDTH       (TW),
        .CTRL_WIDTH           (CW)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .i_start              (i_start),
        .i_abort              (i_abort),
        .i_num_m_tiles        (i_num_m_tiles),
        .i_num_n_tiles        (i_num_n_tiles),
        .i_k_len              (i_k_len),
        .i_top_base           (i_top_base),
        .i_left_base          (i_left_base),
        .i_out_base           (i_out_base),
        .i_sa_valid_down      (i_sa_valid_down),
        .o_ctrl_state         (o_ctrl_state),
        .o_top_rd_start_addr  (o_top_rd_start_addr),
        .o_top_rd_end_addr    (o_top_rd_end_addr),
        .o_left_rd_start_addr (o_left_rd_start_addr),
        .o_left_rd_end_addr   (o_left_rd_end_addr),
        .o_out_base_addr      (o_out_base_addr),
        .o_busy               (o_busy),
        .o_done               (o_done),
        .o_tile_m             (o_tile_m),
        .o_tile_n             (o_tile_n)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (o_done === 1'b1) done_seen++;

    function automatic tile_t obs_tile();
        return {o_tile_m, o_tile_n, o_top_rd_start_addr, o_top_rd_end_addr,
                o_left_rd_start_addr, o_left_rd_end_addr, o_out_base_addr};
    endfunction

    function automatic tile_t exp_tile(input int m, input int n, input int ts, input int te,
                                       input int ls, input int le, input int ob);
        return {TW'(m), TW'(n), AW'(ts), AW'(te), AW'(ls), AW'(le), AW'(ob)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int m, input int n, input int k,
                          input int tb, input int lb, input int ob);
        i_num_m_tiles = TW'(m);
        i_num_n_tiles = TW'(n);
        i_k_len       = AW'(k);
        i_top_base    = AW'(tb);
        i_left_base   = AW'(lb);
        i_out_base    = AW'(ob);
        i_start       = 1'b1;
        step();
        i_start       = 1'b0;
    endtask

    // From an observed S_LOAD, returns how many cycles showed STEADY; stops in DRAIN.
    task automatic count_steady(output int n);
        n = 0;
        step();
        while (o_ctrl_state == CW'(1) && n < 4000) begin
            n++;
            step();
        end
    endtask

    task automatic drive_drain(input int beats, input bit with_gap);
        for (int i = 0; i < beats; i++) begin
            if (with_gap && i == 3) begin
                i_sa_valid_down = 8'h7f;
                step();
            end
            i_sa_valid_down = 8'h80 | 8'(i);
            step();
        end
        i_sa_valid_down = '0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (o_ctrl_state !== 4'd0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got ctrl=%0d busy=%b done=%b, expected 0/0/0", o_ctrl_state, o_busy, o_done);
        end
        vectors++;
        if (obs_tile() !== '0) begin
            miscompares++;
            $display("FAIL reset_tile: got %h expected 0", obs_tile());
        end
        repeat (3) step();
        rst_n = 1'b1;
        step();
        vectors++;
        if (o_busy !== 1'b0 || o_ctrl_state !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_release: got busy=%b ctrl=%0d expected 0/0", o_busy, o_ctrl_state);
        end
    endtask

    task automatic test_single_tile();
        int d0 = done_seen;
        int n;
        launch(1, 1, 4, 0, 0, 0);
        vectors++;
        if (o_busy !== 1'b1 || o_ctrl_state !== 4'd0) begin
            miscompares++;
            $display("FAIL single_load: got busy=%b ctrl=%0d expected 1/0", o_busy, o_ctrl_state);
        end
        vectors++;
        if (obs_tile() !== exp_tile(0, 0, 0, 4, 0, 4, 0)) begin
            miscompares++;
            $display("FAIL single_addr: got %h expected %h", obs_tile(), exp_tile(0, 0, 0, 4, 0, 4, 0));
        end
        count_steady(n);
        vectors++;
        if (n != 19) begin
            miscompares++;
            $display("FAIL single_steady_len: got %0d expected 19", n);
        end
        drive_drain(NUM_ROW - 1, 1'b1);
        vectors++;
        if (o_ctrl_state !== 4'd3) begin
            miscompares++;
            $display("FAIL single_drain_hold: got ctrl=%0d expected 3", o_ctrl_state);
        end
        drive_drain(1, 1'b0);
        vectors++;
        if (o_ctrl_state !== 4'd0 || o_busy !== 1'b1 || o_done !== 1'b0) begin
            miscompares++;
            $display("FAIL single_next: got ctrl=%0d busy=%b done=%b expected 0/1/0", o_ctrl_state, o_busy, o_done);
        end
        step();
        vectors++;
        if (o_done !== 1'b1 || o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_done: got done=%b busy=%b expected 1/0", o_done, o_busy);
        end
        step();
        vectors++;
        if (o_done !== 1'b0 || done_seen != d0 + 1) begin
            miscompares++;
            $display("FAIL single_done_once: got done=%b pulses=%0d expected 0/1", o_done, done_seen - d0);
        end
    endtask

    task automatic test_multi_tile();
        int em[4]  = '{0, 0, 1, 1};
        int en[4]  = '{0, 1, 0, 1};
        int ets[4] = '{10, 13, 10, 13};
        int els[4] = '{20, 20, 23, 23};
        int eo[4]  = '{100, 108, 116, 124};
        int d0 = done_seen;
        int n;
        launch(2, 2, 3, 10, 20, 100);
        for (int t = 0; t < 4; t++) begin
            vectors++;
            if (obs_tile() !== exp_tile(em[t], en[t], ets[t], ets[t] + 3, els[t], els[t] + 3, eo[t])) begin
                miscompares++;
                $display("FAIL multi_addr[%0d]: got %h expected %h", t, obs_tile(),
                         exp_tile(em[t], en[t], ets[t], ets[t] + 3, els[t], els[t] + 3, eo[t]));
            end
            if (t == 0) i_sa_valid_down = '1;
            count_steady(n);
            i_sa_valid_down = '0;
            vectors++;
            if (n != 18) begin
                miscompares++;
                $display("FAIL multi_steady_len[%0d]: got %0d expected 18", t, n);
            end
            drive_drain(NUM_ROW, t[0]);
            step();
            vectors++;
            if (t < 3 && (o_busy !== 1'b1 || o_done !== 1'b0 || o_ctrl_state !== 4'd0)) begin
                miscompares++;
                $display("FAIL multi_reload[%0d]: got busy=%b done=%b ctrl=%0d expected 1/0/0", t, o_busy, o_done, o_ctrl_state);
            end else if (t == 3 && (o_busy !== 1'b0 || o_done !== 1'b1)) begin
                miscompares++;
                $display("FAIL multi_done: got busy=%b done=%b expected 0/1", o_busy, o_done);
            end
        end
        step();
        vectors++;
        if (done_seen != d0 + 1) begin
            miscompares++;
            $display("FAIL multi_done_once: got %0d pulses expected 1", done_seen - d0);
        end
    endtask

    task automatic test_zero_len();
        int zm[3] = '{1, 0, 2};
        int zn[3] = '{1, 3, 0};
        int zk[3] = '{0, 5, 5};
        for (int i = 0; i < 3; i++) begin
            launch(zm[i], zn[i], zk[i], 1, 2, 3);
            vectors++;
            if (o_done !== 1'b1 || o_busy !== 1'b0 || o_ctrl_state !== 4'd0) begin
                miscompares++;
                $display("FAIL zero_done[%0d]: got done=%b busy=%b ctrl=%0d expected 1/0/0", i, o_done, o_busy, o_ctrl_state);
            end
            step();
            vectors++;
            if (o_done !== 1'b0 || o_busy !== 1'b0 || o_ctrl_state !== 4'd0) begin
                miscompares++;
                $display("FAIL zero_idle[%0d]: got done=%b busy=%b ctrl=%0d expected 0/0/0", i, o_done, o_busy, o_ctrl_state);
            end
        end
    endtask

    task automatic test_abort();
        int d0 = done_seen;
        int n;
        launch(1, 2, 2, 0, 0, 0);
        count_steady(n);
        drive_drain(NUM_ROW, 1'b0);
        step();
        vectors++;
        if (obs_tile() !== exp_tile(0, 1, 2, 4, 0, 2, 8)) begin
            miscompares++;
            $display("FAIL abort_tile1: got %h expected %h", obs_tile(), exp_tile(0, 1, 2, 4, 0, 2, 8));
        end
        step();
        step();
        i_abort = 1'b1;
        i_start = 1'b1;
        step();
        vectors++;
        if (o_ctrl_state !== 4'd0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_idle: got ctrl=%0d busy=%b done=%b expected 0/0/0", o_ctrl_state, o_busy, o_done);
        end
        i_abort = 1'b0;
        i_start = 1'b0;
        step();
        step();
        vectors++;
        if (done_seen != d0 || o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_no_done: got pulses=%0d busy=%b expected 0/0", done_seen - d0, o_busy);
        end
        launch(1, 1, 1, 7, 9, 11);
        vectors++;
        if (obs_tile() !== exp_tile(0, 0, 7, 8, 9, 10, 11)) begin
            miscompares++;
            $display("FAIL abort_relaunch_addr: got %h expected %h", obs_tile(), exp_tile(0, 0, 7, 8, 9, 10, 11));
        end
        count_steady(n);
        vectors++;
        if (n != 16) begin
            miscompares++;
            $display("FAIL abort_relaunch_steady: got %0d expected 16", n);
        end
        drive_drain(NUM_ROW, 1'b0);
        step();
        step();
        vectors++;
        if (done_seen != d0 + 1) begin
            miscompares++;
            $display("FAIL abort_relaunch_done: got %0d pulses expected 1", done_seen - d0);
        end
        // abort landing on the final drain beat must win over the exit
        launch(1, 1, 1, 0, 0, 0);
        count_steady(n);
        drive_drain(NUM_ROW - 1, 1'b0);
        i_abort = 1'b1;
        drive_drain(1, 1'b0);
        i_abort = 1'b0;
        vectors++;
        if (o_busy !== 1'b0 || o_ctrl_state !== 4'd0) begin
            miscompares++;
            $display("FAIL abort_drain_exit: got busy=%b ctrl=%0d expected 0/0", o_busy, o_ctrl_state);
        end
        step();
        step();
        vectors++;
        if (done_seen != d0 + 1) begin
            miscompares++;
            $display("FAIL abort_drain_no_done: got %0d pulses expected 1", done_seen - d0);
        end
    endtask

    task automatic test_wrap_and_restart_ignored();
        int d0 = done_seen;
        int n;
        launch(1, 2, 8, 1020, 1000, 1020);
        vectors++;
        if (obs_tile() !== exp_tile(0, 0, 1020, 4, 1000, 1008, 1020)) begin
            miscompares++;
            $display("FAIL wrap_tile0: got %h expected %h", obs_tile(), exp_tile(0, 0, 1020, 4, 1000, 1008, 1020));
        end
        count_steady(n);
        vectors++;
        if (n != 23) begin
            miscompares++;
            $display("FAIL wrap_steady0: got %0d expected 23", n);
        end
        i_num_n_tiles = 8'd1;
        i_k_len       = 10'd1;
        i_top_base    = '0;
        i_out_base    = '0;
        i_start       = 1'b1;
        step();
        i_start       = 1'b0;
        vectors++;
        if (o_ctrl_state !== 4'd3) begin
            miscompares++;
            $display("FAIL wrap_start_ignored: got ctrl=%0d expected 3", o_ctrl_state);
        end
        drive_drain(NUM_ROW, 1'b1);
        step();
        vectors++;
        if (obs_tile() !== exp_tile(0, 1, 4, 12, 1000, 1008, 4)) begin
            miscompares++;
            $display("FAIL wrap_tile1: got %h expected %h", obs_tile(), exp_tile(0, 1, 4, 12, 1000, 1008, 4));
        end
        count_steady(n);
        vectors++;
        if (n != 23) begin
            miscompares++;
            $display("FAIL wrap_steady1: got %0d expected 23", n);
        end
        drive_drain(NUM_ROW, 1'b0);
        step();
        step();
        vectors++;
        if (done_seen != d0 + 1) begin
            miscompares++;
            $display("FAIL wrap_done: got %0d pulses expected 1", done_seen - d0);
        end
    endtask

    task automatic test_reset_mid_drain();
        int d0 = done_seen;
        int n;
        launch(1, 1, 2, 3, 4, 5);
        count_steady(n);
        drive_drain(3, 1'b0);
        vectors++;
        if (o_ctrl_state !== 4'd3) begin
            miscompares++;
            $display("FAIL rstmid_in_drain: got ctrl=%0d expected 3", o_ctrl_state);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (o_ctrl_state !== 4'd0 || o_busy !== 1'b0 || o_done !== 1'b0 || obs_tile() !== '0) begin
            miscompares++;
            $display("FAIL rstmid_clear: got ctrl=%0d busy=%b done=%b tile=%h expected all 0",
                     o_ctrl_state, o_busy, o_done, obs_tile());
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        vectors++;
        if (done_seen != d0 || o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_no_done: got pulses=%0d busy=%b expected 0/0", done_seen - d0, o_busy);
        end
        launch(1, 1, 2, 5, 6, 7);
        vectors++;
        if (obs_tile() !== exp_tile(0, 0, 5, 7, 6, 8, 7)) begin
            miscompares++;
            $display("FAIL rstmid_relaunch_addr: got %h expected %h", obs_tile(), exp_tile(0, 0, 5, 7, 6, 8, 7));
        end
        count_steady(n);
        vectors++;
        if (n != 17) begin
            miscompares++;
            $display("FAIL rstmid_relaunch_steady: got %0d expected 17", n);
        end
        drive_drain(NUM_ROW, 1'b1);
        step();
        vectors++;
        if (o_done !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_relaunch_done: got %b expected 1", o_done);
        end
        step();
        vectors++;
        if (done_seen != d0 + 1) begin
            miscompares++;
            $display("FAIL rstmid_done_once: got %0d pulses expected 1", done_seen - d0);
        end
    endtask

    initial begin
        test_reset();
        test_single_tile();
        test_multi_tile();
        test_zero_len();
        test_abort();
        test_wrap_and_restart_ignored();
        test_reset_mid_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
